lsu_mem_master: RTL and testbench

- Load/store initiator that drives the single-port data memory (registered read, 1-cycle read latency, word-wide, no byte enables) on behalf of the core pipeline.
- Converts byte-addressed byte/half/word requests into word-addressed memory accesses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Sits between the execute/memory stage and the data memory.

---
 rtl/lsu_mem_master_if.sv | 38 +++
 rtl/lsu_mem_master.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Bundles the core request/response handshake and the data memory port of the LSU.
// The master modport is the LSU's view; the slave modport is the core-plus-memory side.
interface lsu_mem_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_error;

  logic                  mem_readEnable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_readData;
  logic                  mem_writeEnable;
  logic [DATA_WIDTH-1:0] mem_writeData;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_readData,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_readEnable, mem_address, mem_writeEnable, mem_writeData
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_readData,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_readEnable, mem_address, mem_writeEnable, mem_writeData
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide single-port memory with 1-cycle registered reads.
// Sub-word stores are read-modify-write; loads are sign/zero extended from the selected lane.
module lsu_mem_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic              clock,
  input logic              reset,
  lsu_mem_master_if.master bus
);

  // state         | meaning
  // S_IDLE        | ready for a request; word stores and errors complete from here
  // S_LOAD_WAIT   | read data arrives this cycle; extend and respond
  // S_STORE_MERGE | read data arrives this cycle; merge the lane and write back
  typedef enum logic [1:0] {S_IDLE, S_LOAD_WAIT, S_STORE_MERGE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic                  misalign;
  logic [4:0]            lane_shift;
  logic [DATA_WIDTH-1:0] lane, load_ext, lane_mask, merged;

  always_comb begin
    misalign = (bus.req_size == 2'd3)
             | ((bus.req_size == 2'd1) & bus.req_addr[0])
             | ((bus.req_size == 2'd2) & (|bus.req_addr[1:0]));

    lane_shift = {off_q, 3'b000};
    lane       = bus.mem_readData >> lane_shift;
    case (size_q)
      2'd0:    load_ext = uns_q ? {{(DATA_WIDTH-8){1'b0}}, lane[7:0]}
                                : {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      2'd1:    load_ext = uns_q ? {{(DATA_WIDTH-16){1'b0}}, lane[15:0]}
                                : {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase

    lane_mask = (size_q == 2'd0) ? (DATA_WIDTH'(8'hFF) << lane_shift)
                                 : (DATA_WIDTH'(16'hFFFF) << lane_shift);
    merged    = (bus.mem_readData & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  always_comb begin
    state_d             = state_q;
    waddr_d             = waddr_q;
    off_d               = off_q;
    size_d              = size_q;
    uns_d               = uns_q;
    wdata_d             = wdata_q;
    valid_d             = 1'b0;
    rdata_d             = rdata_q;
    error_d             = error_q;
    bus.req_ready       = 1'b0;
    bus.mem_readEnable  = 1'b0;
    bus.mem_writeEnable = 1'b0;
    bus.mem_address     = '0;
    bus.mem_writeData   = '0;

    // Everything facing the core and the memory is held quiet while reset is low.
    if (reset) begin
      case (state_q)
        S_IDLE: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            if (misalign) begin
              valid_d = 1'b1;
              rdata_d = '0;
              error_d = 1'b1;
            end else if (bus.req_write && bus.req_size == 2'd2) begin
              bus.mem_writeEnable = 1'b1;
              bus.mem_address     = bus.req_addr[ADDR_WIDTH+1:2];
              bus.mem_writeData   = bus.req_wdata;
              valid_d             = 1'b1;
              rdata_d             = '0;
              error_d             = 1'b0;
            end else begin
              bus.mem_readEnable = 1'b1;
              bus.mem_address    = bus.req_addr[ADDR_WIDTH+1:2];
              waddr_d            = bus.req_addr[ADDR_WIDTH+1:2];
              off_d              = bus.req_addr[1:0];
              size_d             = bus.req_size;
              uns_d              = bus.req_unsigned;
              wdata_d            = bus.req_wdata;
              state_d            = bus.req_write ? S_STORE_MERGE : S_LOAD_WAIT;
            end
          end
        end
        S_LOAD_WAIT: begin
          valid_d = 1'b1;
          rdata_d = load_ext;
          error_d = 1'b0;
          state_d = S_IDLE;
        end
        S_STORE_MERGE: begin
          bus.mem_writeEnable = 1'b1;
          bus.mem_address     = waddr_q;
          bus.mem_writeData   = merged;
          valid_d             = 1'b1;
          rdata_d             = '0;
          error_d             = 1'b0;
          state_d             = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: a word memory model on the bus, a byte-array reference of
// memory contents, directed vectors, multi-cycle handshake/reset sequences and random traffic.
module tb_lsu_mem_master;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

  lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Data memory: registered read, write-first not needed since enables are exclusive.
  logic [31:0] mem_words [0:1023];
  always @(posedge clk) begin
    if (bus.mem_writeEnable) mem_words[bus.mem_address] <= bus.mem_writeData;
    if (bus.mem_readEnable)  bus.mem_readData <= mem_words[bus.mem_address];
    if (bus.mem_readEnable && bus.mem_writeEnable) begin
      n_total++;
      $display("FAIL enables_exclusive: readEnable=1 writeEnable=1, required not both");
    end
  end

  // Reference model: memory as bytes, little-endian.
  logic [7:0] ref_bytes [0:4095];

  function automatic void ref_store(input logic [11:0] addr, input logic [1:0] sz,
                                    input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_bytes[addr + 12'(i)] = wd[8*i +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [11:0] addr, input logic [1:0] sz,
                                           input bit uns);
    logic [31:0] v;
    int n;
    v = 0;
    n = 1 << sz;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[addr + 12'(i)]) << (8*i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic bit ref_err(input logic [11:0] addr, input logic [1:0] sz);
    return (sz == 2'd3) || ((int'(addr) % (1 << sz)) != 0);
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endfunction

  task automatic do_req(input string nm, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [11:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    int  waitc;
    int  lat;
    bit  acc_en;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    #1;
    waitc = 0;
    while (!bus.req_ready && waitc < 10) begin
      @(negedge clk); #1; waitc++;
    end
    check({nm, " ready"}, 32'(bus.req_ready), 32'd1);
    acc_en = bus.mem_readEnable | bus.mem_writeEnable;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus.resp_valid && lat < 6) begin
      @(negedge clk); #1; lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " rdata"}, bus.resp_rdata, exp_rd);
    check({nm, " error"}, 32'(bus.resp_error), 32'(exp_err));
    if (exp_err) check({nm, " no_mem_access"}, 32'(acc_en), 32'd0);
    if (wr && !exp_err) ref_store(addr, sz, wd);
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          uns;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [31:0] exp_v;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h00;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 12'h020, 32'h11223344, 32'h0,        1'b0, 1};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 12'h022, 32'h000000AB, 32'h0,        1'b0, 2};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 12'h020, 32'h0,        32'h11AB3344, 1'b0, 2};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 12'h022, 32'h0,        32'hFFFFFFAB, 1'b0, 2};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 12'h022, 32'h0,        32'h000000AB, 1'b0, 2};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 12'h030, 32'hCAFEBABE, 32'h0,        1'b0, 1};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 12'h032, 32'h00008001, 32'h0,        1'b0, 2};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 12'h030, 32'h0,        32'h8001BABE, 1'b0, 2};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 12'h032, 32'h0,        32'hFFFF8001, 1'b0, 2};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 12'h030, 32'h0,        32'h0000BABE, 1'b0, 2};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 12'h040, 32'h12345678, 32'h0,        1'b0, 1};
    vecs[13] = '{1'b0, 2'd1, 1'b0, 12'h041, 32'h0,        32'h0,        1'b1, 1};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 12'h042, 32'hFFFFFFFF, 32'h0,        1'b1, 1};
    vecs[15] = '{1'b0, 2'd3, 1'b0, 12'h040, 32'h0,        32'h0,        1'b1, 1};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 12'h040, 32'h0,        32'h12345678, 1'b0, 2};

    // Reset state and output gating.
    repeat (3) @(negedge clk);
    #1;
    check("rst ready", 32'(bus.req_ready), 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst mem_re", 32'(bus.mem_readEnable), 32'd0);
    check("rst mem_we", 32'(bus.mem_writeEnable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst ready", 32'(bus.req_ready), 32'd1);
    check("post_rst rdata", bus.resp_rdata, 32'd0);
    check("post_rst error", 32'(bus.resp_error), 32'd0);

    // Clear the region used below so memory and reference agree.
    for (int a = 0; a < 128; a += 4) do_req("clear", 1'b1, 2'd2, 1'b0, 12'(a), 32'h0, 32'h0, 1'b0, 1);

    for (int i = 0; i < 17; i++)
      do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
             vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].lat);

    // Four back-to-back word stores, each acknowledged the following cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
      bus.req_addr = 12'h060 + 12'(4*k);
      bus.req_wdata = $urandom;
      #1;
      check("b2b ready", 32'(bus.req_ready), 32'd1);
      check("b2b ack", 32'(bus.resp_valid), 32'(k > 0));
      ref_store(bus.req_addr, 2'd2, bus.req_wdata);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("b2b last ack", 32'(bus.resp_valid), 32'd1);

    // Load then byte store held continuously: ready drops for one cycle after each.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 12'h060; bus.req_wdata = 32'h0;
    exp_v = ref_load(12'h060, 2'd2, 1'b0);
    #1;
    check("ld_st ready0", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_addr = 12'h061; bus.req_wdata = 32'h0000005A;
    #1;
    check("ld_st ready1", 32'(bus.req_ready), 32'd0);
    check("ld_st resp1", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    #1;
    check("ld_st ready2", 32'(bus.req_ready), 32'd1);
    check("ld_st resp2", 32'(bus.resp_valid), 32'd1);
    check("ld_st load data", bus.resp_rdata, exp_v);
    ref_store(12'h061, 2'd0, 32'h0000005A);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("ld_st ready3", 32'(bus.req_ready), 32'd0);
    check("ld_st resp3", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    #1;
    check("ld_st ready4", 32'(bus.req_ready), 32'd1);
    check("ld_st resp4", 32'(bus.resp_valid), 32'd1);
    do_req("ld_st readback", 1'b0, 2'd2, 1'b0, 12'h060, 32'h0, ref_load(12'h060, 2'd2, 1'b0), 1'b0, 2);

    // Reset during the merge cycle of a byte store abandons it.
    do_req("rst_op prep", 1'b1, 2'd2, 1'b0, 12'h050, 32'h55555555, 32'h0, 1'b0, 1);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 12'h050; bus.req_wdata = 32'h000000AA;
    #1;
    check("rst_op accept", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("rst_op no write", 32'(bus.mem_writeEnable), 32'd0);
    check("rst_op ready low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_op no resp", 32'(bus.resp_valid), 32'd0);
    check("rst_op ready", 32'(bus.req_ready), 32'd1);
    do_req("rst_op readback", 1'b0, 2'd2, 1'b0, 12'h050, 32'h0, 32'h55555555, 1'b0, 2);

    // Random traffic against the byte-level reference.
    for (int it = 0; it < 200; it++) begin
      bit          wr, uns, err;
      logic [1:0]  sz;
      logic [11:0] addr;
      logic [31:0] wd, erd;
      int          lat;
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = 12'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) addr = addr & ~12'((1 << sz) - 1);
      wd   = $urandom;
      err  = ref_err(addr, sz);
      erd  = (wr || err) ? 32'h0 : ref_load(addr, sz, uns);
      lat  = (err || (wr && sz == 2'd2)) ? 1 : 2;
      do_req("rand", wr, sz, uns, addr, wd, erd, err, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
